// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - phase-aligned MCLK/BCLK/LRCLK generator with clk_in-domain strobes
//
// Ports:
//   clk_in         system clock
//   rst            asynchronous reset, active-high
//   en             run request, level-sensitive; sampled only at frame end while running
//   mclk_out       codec master clock, clk_in / MCLK_DIV
//   bclk_out       bit clock, clk_in / (MCLK_DIV*BCLK_DIV)
//   lrclk_out      word select, 0 = left, 1 = right
//   bclk_rise_stb  high the clk_in cycle before bclk_out rises
//   bclk_fall_stb  high the clk_in cycle before bclk_out falls and bit_idx advances
//   frame_stb      high the clk_in cycle before a new frame starts
//   bit_idx        BCLK index within the frame
//   running        high while in RUN
//
// Optional build macro: I2S_CLK_GEN_MCLK_FREE_EN keeps mcnt/mclk_out running in IDLE
// and delays RUN entry until the mcnt wrap so MCLK and BCLK stay phase-aligned.
module i2s_clk_gen #(
    parameter int MCLK_DIV   = 4,
    parameter int BCLK_DIV   = 4,
    parameter int FRAME_BITS = 64
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          en,
    output logic                          mclk_out,
    output logic                          bclk_out,
    output logic                          lrclk_out,
    output logic                          bclk_rise_stb,
    output logic                          bclk_fall_stb,
    output logic                          frame_stb,
    output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
    output logic                          running
);

    localparam int P  = MCLK_DIV * BCLK_DIV;
    localparam int PW = $clog2(P);
    localparam int MW = $clog2(MCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
            $error("i2s_clk_gen: MCLK_DIV must be even and >= 2");
        end
        if (BCLK_DIV < 1) begin : g_bad_bclk_div
            $error("i2s_clk_gen: BCLK_DIV must be >= 1");
        end
        if (FRAME_BITS < 2 || (FRAME_BITS % 2) != 0) begin : g_bad_frame_bits
            $error("i2s_clk_gen: FRAME_BITS must be even and >= 2");
        end
    endgenerate

    logic [0:0]    state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [MW-1:0] mcnt, mcnt_n;
    logic [BW-1:0] bit_n;

    logic pcnt_wrap, mcnt_wrap, bit_wrap;

    assign pcnt_wrap = (pcnt == PW'(P - 1));
    assign mcnt_wrap = (mcnt == MW'(MCLK_DIV - 1));
    assign bit_wrap  = (bit_idx == BW'(FRAME_BITS - 1));

    assign running       = state[0];
    assign bclk_rise_stb = running && (pcnt == PW'(P / 2 - 1));
    assign bclk_fall_stb = running && pcnt_wrap;
    assign frame_stb     = bclk_fall_stb && bit_wrap;

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        mcnt_n  = mcnt;
        bit_n   = bit_idx;
`ifdef I2S_CLK_GEN_MCLK_FREE_EN
        // MCLK never stops once out of reset.
        mcnt_n  = mcnt_wrap ? '0 : mcnt + 1'b1;
`endif
        case (state)
            ST_IDLE: begin
                pcnt_n = '0;
                bit_n  = '0;
`ifdef I2S_CLK_GEN_MCLK_FREE_EN
                // Entering on the wrap makes the first RUN cycle have mcnt == pcnt == 0.
                if (en && mcnt_wrap) begin
                    state_n = ST_RUN;
                end
`else
                mcnt_n = '0;
                if (en) begin
                    state_n = ST_RUN;
                end
`endif
            end
            default: begin
                pcnt_n = pcnt_wrap ? '0 : pcnt + 1'b1;
                mcnt_n = mcnt_wrap ? '0 : mcnt + 1'b1;
                if (pcnt_wrap) begin
                    bit_n = bit_wrap ? '0 : bit_idx + 1'b1;
                end
                // en only matters at the frame boundary so frames are never cut short.
                if (pcnt_wrap && bit_wrap && !en) begin
                    state_n = ST_IDLE;
                    pcnt_n  = '0;
                    bit_n   = '0;
`ifndef I2S_CLK_GEN_MCLK_FREE_EN
                    mcnt_n  = '0;
`endif
                end
            end
        endcase
    end

    // Output clocks are derived from the next-state counters so they change on
    // the same edge as the counters they decode.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pcnt      <= '0;
            mcnt      <= '0;
            bit_idx   <= '0;
            mclk_out  <= 1'b0;
            bclk_out  <= 1'b0;
            lrclk_out <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            mcnt      <= mcnt_n;
            bit_idx   <= bit_n;
            mclk_out  <= (mcnt_n >= MW'(MCLK_DIV / 2));
            bclk_out  <= (state_n == ST_RUN) && (pcnt_n >= PW'(P / 2));
            lrclk_out <= (state_n == ST_RUN) && (bit_n >= BW'(FRAME_BITS / 2));
        end
    end

endmodule

// File: tb/tb_i2s_clk_gen.sv
// tb/tb_i2s_clk_gen.sv - scoreboard testbench for i2s_clk_gen
module tb_i2s_clk_gen;

    localparam int MD    = 4;
    localparam int P     = 16;
    localparam int FB    = 64;
    localparam int FRAME = P * FB;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic en_a   = 1'b0;
    logic en_b   = 1'b0;

    logic       mclk_a, bclk_a, lr_a, rise_a, fall_a, frm_a, run_a;
    logic [5:0] bidx_a;
    logic       mclk_b, bclk_b, lr_b, rise_b, fall_b, frm_b, run_b;
    logic [4:0] bidx_b;

    i2s_clk_gen u_dut_a (
        .clk_in        (clk_in),
        .rst           (rst),
        .en            (en_a),
        .mclk_out      (mclk_a),
        .bclk_out      (bclk_a),
        .lrclk_out     (lr_a),
        .bclk_rise_stb (rise_a),
        .bclk_fall_stb (fall_a),
        .frame_stb     (frm_a),
        .bit_idx       (bidx_a),
        .running       (run_a)
    );

    i2s_clk_gen #(.MCLK_DIV(8), .BCLK_DIV(2), .FRAME_BITS(32)) u_dut_b (
        .clk_in        (clk_in),
        .rst           (rst),
        .en            (en_b),
        .mclk_out      (mclk_b),
        .bclk_out      (bclk_b),
        .lrclk_out     (lr_b),
        .bclk_rise_stb (rise_b),
        .bclk_fall_stb (fall_b),
        .frame_stb     (frm_b),
        .bit_idx       (bidx_b),
        .running       (run_b)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];

    // Expected-behaviour state of DUT A as seen by the bench.
    bit mrun = 1'b0;
    int r    = 0;
    int rel  = 0;

    // {running, mclk, bclk, lrclk, rise, fall, frame, bit_idx}
    function automatic logic [12:0] exp_vec(input bit run, input int rr, input bit m);
        int pc, bi;
        logic [5:0] b6;
        pc = rr % P;
        bi = (rr / P) % FB;
        b6 = 6'(bi);
        if (!run) return {1'b0, m, 11'b0};
        return {1'b1, m, pc >= P / 2, bi >= FB / 2, pc == P / 2 - 1,
                pc == P - 1, (pc == P - 1) && (bi == FB - 1), b6};
    endfunction

    function automatic bit entry_ok(input int c);
`ifdef I2S_CLK_GEN_MCLK_FREE_EN
        return ((c - rel) % MD) == MD - 1;
`else
        return (c >= 0);
`endif
    endfunction

    function automatic bit exp_mclk(input int c);
`ifdef I2S_CLK_GEN_MCLK_FREE_EN
        return ((c - rel) % MD) >= MD / 2;
`else
        return mrun && ((r % MD) >= MD / 2) && (c >= 0);
`endif
    endfunction

    // Called at a negedge: drives en for the coming edge and queues the
    // expected outputs for the cycle after it.
    task automatic tick(input bit en_v);
        int c;
        c    = cyc;
        en_a = en_v;
        if (!mrun) begin
            if (en_v && entry_ok(c)) begin
                mrun = 1'b1;
                r    = 0;
            end
        end else if ((r % FRAME) == FRAME - 1 && !en_v) begin
            mrun = 1'b0;
            r    = 0;
        end else begin
            r = r + 1;
        end
        q.push_back('{c + 1, exp_vec(mrun, r, exp_mclk(c + 1))});
        @(negedge clk_in);
    endtask

    // Scoreboard monitor: pops the vector queued for this cycle and compares.
    always @(negedge clk_in) begin
        exp_t e;
        logic [12:0] act;
        act = {run_a, mclk_a, bclk_a, lr_a, rise_a, fall_a, frm_a, bidx_a};
        while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            tests = tests + 1;
            if (act !== e.v) begin
                fails = fails + 1;
                $display("FAIL vec@%0d: got %b expected %b", cyc, act, e.v);
            end
        end
    end

    // Event monitor: timing relations between strobes and clock edges.
    int   run_start = -1, last_frm = -1, last_rise_b = -1, last_frm_b = -1, frames_b = 0;
    bit   seen_rise = 1'b0;
    logic prev_run = 1'b0, prev_lr = 1'b0, prev_mb = 1'b0, prev_bb = 1'b0;

    always @(negedge clk_in) begin
        if (rst) begin
            run_start   = -1;
            last_frm    = -1;
            last_rise_b = -1;
            last_frm_b  = -1;
            seen_rise   = 1'b0;
            prev_run    = 1'b0;
            prev_lr     = 1'b0;
            prev_mb     = 1'b0;
            prev_bb     = 1'b0;
        end else begin
            if (run_a && !prev_run) begin
                run_start = cyc;
                seen_rise = 1'b0;
                last_frm  = -1;
            end
            if (run_a && rise_a && !seen_rise) begin
                seen_rise = 1'b1;
                check("first_rise_stb", cyc - run_start, 7);
            end
            if (lr_a && !prev_lr) check("lrclk_rise", (cyc - run_start) % FRAME, 512);
            if (frm_a) begin
                if (last_frm >= 0) check("frame_gap", cyc - last_frm, FRAME);
                last_frm = cyc;
            end
            if (bclk_b != prev_bb) check("b_edge_on_mclk_fall", {30'd0, prev_mb, mclk_b}, 2);
            if (!run_b) begin
                last_rise_b = -1;
                last_frm_b  = -1;
            end
            if (bclk_b && !prev_bb) begin
                if (last_rise_b >= 0) check("b_bclk_period", cyc - last_rise_b, 16);
                last_rise_b = cyc;
            end
            if (frm_b) begin
                if (last_frm_b >= 0) check("b_frame_gap", cyc - last_frm_b, 512);
                last_frm_b = cyc;
                frames_b   = frames_b + 1;
            end
            prev_run = run_a;
            prev_lr  = lr_a;
            prev_mb  = mclk_b;
            prev_bb  = bclk_b;
        end
    end

    function automatic int all_outs();
        return int'({mclk_a, bclk_a, lr_a, rise_a, fall_a, frm_a, bidx_a, run_a,
                     mclk_b, bclk_b, lr_b, rise_b, fall_b, frm_b, bidx_b, run_b});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        rel = cyc;

        // Idle, then run; in the free-MCLK build raise en when mcnt == 1.
        repeat (6) tick(1'b0);
`ifdef I2S_CLK_GEN_MCLK_FREE_EN
        for (int i = 0; i < 8 && ((cyc - rel) % MD) != 1; i++) tick(1'b0);
`endif
        repeat (1200) tick(1'b1);

        // en low for 100 cycles mid-frame must not disturb anything.
        repeat (100) tick(1'b0);

        // Run to bit_idx 10 of the third frame, then request stop.
        for (int i = 0; i < 3000 && !(mrun && r == 2 * FRAME + 10 * P); i++) tick(1'b1);
        check("reached_stop_point", int'(run_a && bidx_a == 6'd10), 1);
        for (int i = 0; i < 2000 && mrun; i++) tick(1'b0);
        repeat (5) tick(1'b0);
        check("stopped_idle", {31'd0, run_a}, 0);

        // Restart from frame start, then reset asynchronously mid-run.
        repeat (1100) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        q.delete();
        mrun = 1'b0;
        r    = 0;
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("reset_hold_outputs", all_outs(), 0);
        end
        rst = 1'b0;
        rel = cyc;
        repeat (8) tick(1'b0);

        // Non-default instance: two full frames then graceful stop.
        en_b = 1'b1;
        repeat (1100) @(negedge clk_in);
        en_b = 1'b0;
        for (int i = 0; i < 700 && run_b; i++) @(negedge clk_in);
        check("b_stopped", {31'd0, run_b}, 0);
        check("b_frames_seen", int'(frames_b >= 2), 1);
        check("b_outputs_idle", int'({bclk_b, lr_b, bidx_b}), 0);

        @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
